iob_bus_arbiter2: RTL

- Two-requester arbiter that shares one IOb native memory port between an instruction bus (requester 0) and a data bus (requester 1).
- Placed between the CPU wrapper's split ibus/dbus and a single-ported memory or interconnect slave. The same block also serves a CPU+DMA pair.
- Allows one outstanding read at a time and routes the read response back to the requester that issued it.

---
 rtl/iob_bus_arbiter2_pkg.sv | 44 ++++
 rtl/iob_bus_arbiter2_rr2.sv | 54 +++++
 rtl/iob_bus_arbiter2.sv | 108 ++++++++++
 3 files changed

// File: rtl/iob_bus_arbiter2_pkg.sv
// Shared definitions for the two-requester IOb arbiter.
// Holds the state encoding and the IOb field layout:
//   request  = {avalid, addr[ADDR_W], wdata[DATA_W], wstrb[STRB_W]}, MSB first
//   response = {rdata[DATA_W], rvalid, ready}, MSB first
// The width and offset helpers let every file derive the same bit positions
// from ADDR_W/DATA_W.
package iob_bus_arbiter2_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_RD = 1'b1
    } arb_state_t;

    // Fixed response field positions.
    localparam int READY_POS  = 0;
    localparam int RVALID_POS = 1;
    localparam int RDATA_LSB  = 2;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_w(input int dw);
        return dw + 2;
    endfunction

    // Request field positions; wstrb sits at bit 0.
    function automatic int wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw / 8 + dw;
    endfunction

    function automatic int avalid_pos(input int aw, input int dw);
        return dw / 8 + dw + aw;
    endfunction

endpackage

// File: rtl/iob_bus_arbiter2_rr2.sv
// iob_arb_rr2: two-way grant selection with a grant lock.
// Ports:
//   clk, arst_n  clock and async active-low reset
//   cke          clock enable; registers hold when 0
//   req[1:0]     per-requester avalid (forced to 0 by the caller when not arbitrating)
//   accept       granted request was accepted this cycle
//   grant        selected requester (0 or 1)
// RR_EN=1 alternates on ties using the last accepted requester; RR_EN=0 lets
// requester 1 win ties. Once a granted request stalls, the grant is locked
// to it until it is accepted or withdrawn.
module iob_arb_rr2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       cke,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);

    logic last;
    logic hold_v;
    logic hold_id;

    always_comb begin
        grant = 1'b0;
        if (hold_v) begin
            grant = hold_id;
        end else begin
            case (req)
                2'b01:   grant = 1'b0;
                2'b10:   grant = 1'b1;
                2'b11:   grant = RR_EN ? ~last : 1'b1;
                default: grant = 1'b0;
            endcase
        end
    end

    // The lock is simply "granted request still pending": it drops either on
    // acceptance or when the requester withdraws avalid.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last    <= 1'b1;   // requester 0 wins the first tie
            hold_v  <= 1'b0;
            hold_id <= 1'b0;
        end else if (cke) begin
            hold_v  <= req[grant] & ~accept;
            hold_id <= grant;
            if (accept) last <= grant;
        end
    end

endmodule

// File: rtl/iob_bus_arbiter2.sv
// iob_bus_arbiter2: shares one IOb port between requester 0 (ibus/CPU) and
// requester 1 (dbus/DMA), with one outstanding read at a time.
// Ports:
//   clk_i, arst_n_i       clock, async active-low reset
//   cke_i                 clock enable; registers hold, forwarding stays live
//   s0_req_i/s0_resp_o    requester 0 request/response
//   s1_req_i/s1_resp_o    requester 1 request/response
//   m_req_o/m_resp_i      shared port request/response
//   busy_o                a read is outstanding
// Requests are forwarded combinationally in IDLE; an accepted read moves to
// WAIT_RD until the single rvalid returns, which is routed to the owner.
module iob_bus_arbiter2
    import iob_bus_arbiter2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                arst_n_i,
    input  logic                                cke_i,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]    s0_req_i,
    output logic [resp_w(DATA_W)-1:0]           s0_resp_o,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]    s1_req_i,
    output logic [resp_w(DATA_W)-1:0]           s1_resp_o,
    output logic [req_w(ADDR_W, DATA_W)-1:0]    m_req_o,
    input  logic [resp_w(DATA_W)-1:0]           m_resp_i,
    output logic                                busy_o
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int STRB_W = strb_w(DATA_W);
    localparam int AV     = avalid_pos(ADDR_W, DATA_W);

    arb_state_t        state, state_nxt;
    logic              owner;
    logic              grant;
    logic              idle;
    logic [1:0]        avalid;
    logic [1:0]        arb_req;
    logic [REQ_W-1:0]  gnt_req;
    logic              m_ready;
    logic              m_rvalid;
    logic              accept;
    logic              is_rd;

    assign idle     = (state == ST_IDLE);
    assign avalid   = {s1_req_i[AV], s0_req_i[AV]};
    assign arb_req  = idle ? avalid : 2'b00;
    assign gnt_req  = grant ? s1_req_i : s0_req_i;
    assign m_ready  = m_resp_i[READY_POS];
    assign m_rvalid = m_resp_i[RVALID_POS];
    assign accept   = arst_n_i & idle & gnt_req[AV] & m_ready;
    assign is_rd    = (gnt_req[STRB_W-1:0] == '0);

    iob_arb_rr2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk    (clk_i),
        .arst_n (arst_n_i),
        .cke    (cke_i),
        .req    (arb_req),
        .accept (accept),
        .grant  (grant)
    );

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= ST_IDLE;
            owner <= 1'b0;
        end else if (cke_i) begin
            state <= state_nxt;
            if (accept && is_rd) owner <= grant;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept && is_rd) state_nxt = ST_WAIT_RD;
            ST_WAIT_RD: if (m_rvalid)        state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. Gated by the reset pin so nothing is forwarded while it is held,
    // and an rvalid seen in IDLE (stray or post-reset) never reaches a requester.
    always_comb begin
        m_req_o   = '0;
        s0_resp_o = '0;
        s1_resp_o = '0;
        busy_o    = 1'b0;
        if (arst_n_i) begin
            if (idle) begin
                m_req_o = gnt_req;
                if (grant) s1_resp_o[READY_POS] = m_ready;
                else       s0_resp_o[READY_POS] = m_ready;
            end else begin
                busy_o = 1'b1;
                if (owner) s1_resp_o = {m_resp_i[DATA_W+1:RDATA_LSB], m_rvalid, 1'b0};
                else       s0_resp_o = {m_resp_i[DATA_W+1:RDATA_LSB], m_rvalid, 1'b0};
            end
        end
    end

endmodule
